hs_fanout_fifo: RTL and testbench



---
 rtl/hs_pkg.sv | 18 +
 rtl/hs_fanout_port.sv | 46 ++++
 rtl/hs_fanout_fifo.sv | 107 ++++++++++
 tb/tb_hs_fanout_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared constants and pointer helpers for the hs_fanout_fifo block.
package hs_pkg;
   localparam int HS_CNT_W = 32;

   function automatic int hs_clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Occupancy between two wrap-bit pointers of width pw.
   function automatic int hs_ptr_diff(input int a, input int b, input int pw);
      return (a - b) & ((1 << pw) - 1);
   endfunction
endpackage

// File: rtl/hs_fanout_port.sv
// One consumer read port: private read pointer, one-cycle ack pulse, held data register.
module hs_fanout_port
   import hs_pkg::*;
#(
   parameter int data_width = 32,
   parameter int ptr_w      = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req,
   input  logic [ptr_w-1:0]      wr_ptr,
   input  logic [data_width-1:0] rd_word,
   output logic [ptr_w-1:0]      rd_ptr,
   output logic [ptr_w-1:0]      rd_ptr_nxt,
   output logic                  ack,
   output logic [data_width-1:0] dout
`ifdef HS_FANOUT_STATS_EN
   ,
   output logic [HS_CNT_W-1:0]   count_out
`endif
);
   logic fire;

   // Gating on the registered ack spaces acks at least one idle cycle apart.
   assign fire       = req && !ack && (hs_ptr_diff(int'(wr_ptr), int'(rd_ptr), ptr_w) != 0);
   assign rd_ptr_nxt = rd_ptr + {{(ptr_w-1){1'b0}}, fire};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         ack    <= 1'b0;
         dout   <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         ack    <= fire;
         if (fire) dout <= rd_word;
      end
   end

`ifdef HS_FANOUT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   count_out <= '0;
      else if (ack) count_out <= count_out + HS_CNT_W'(1);
   end
`endif
endmodule

// File: rtl/hs_fanout_fifo.sv
// Elastic fan-out buffer: pulls words upstream via req_l/ack_l, replays each to every consumer in order.
// Optional word counters enabled by defining HS_FANOUT_STATS_EN.
module hs_fanout_fifo
   import hs_pkg::*;
#(
   parameter int data_width  = 32,
   parameter int depth       = 4,
   parameter int output_size = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   output logic                              req_l,
   input  logic                              ack_l,
   input  logic [data_width-1:0]             din,
   input  logic [output_size-1:0]            req_r,
   output logic [output_size-1:0]            ack_r,
`ifdef HS_FANOUT_STATS_EN
   output logic [HS_CNT_W-1:0]               count_in,
   output logic [HS_CNT_W*output_size-1:0]   count_out,
`endif
   output logic [data_width*output_size-1:0] dout
);
   localparam int aw    = hs_clog2(depth);
   localparam int ptr_w = aw + 1;

   logic [data_width-1:0] mem        [depth];
   logic [ptr_w-1:0]      wr_ptr;
   logic [ptr_w-1:0]      wr_ptr_nxt;
   logic [ptr_w-1:0]      rd_ptr     [output_size];
   logic [ptr_w-1:0]      rd_ptr_nxt [output_size];
   logic [data_width-1:0] rd_word    [output_size];
   int                    used;
   int                    used_nxt;
   int                    free_nxt;
   logic                  full;
   logic                  wr_en;
   logic                  req_l_nxt;

   // Occupancy is set by the slowest consumer, both now and after this edge.
   always_comb begin
      used     = 0;
      used_nxt = 0;
      for (int k = 0; k < output_size; k++) begin
         if (hs_ptr_diff(int'(wr_ptr), int'(rd_ptr[k]), ptr_w) > used)
            used = hs_ptr_diff(int'(wr_ptr), int'(rd_ptr[k]), ptr_w);
         if (hs_ptr_diff(int'(wr_ptr_nxt), int'(rd_ptr_nxt[k]), ptr_w) > used_nxt)
            used_nxt = hs_ptr_diff(int'(wr_ptr_nxt), int'(rd_ptr_nxt[k]), ptr_w);
      end
   end

   assign full       = (used == depth);
   assign wr_en      = ack_l && !full;
   assign wr_ptr_nxt = wr_ptr + {{aw{1'b0}}, wr_en};
   assign free_nxt   = depth - used_nxt;
   // Holding the last slot back while a request is up absorbs an ack already in flight.
   assign req_l_nxt  = (free_nxt >= 2) || ((free_nxt == 1) && !req_l);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         req_l  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         req_l  <= req_l_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[aw-1:0]] <= din;
   end

`ifdef HS_FANOUT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     count_in <= '0;
      else if (wr_en) count_in <= count_in + HS_CNT_W'(1);
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && ack_l && full) $error("hs_fanout_fifo: ack_l while full, word dropped");
   end
`endif

   for (genvar g = 0; g < output_size; g++) begin : g_port
      assign rd_word[g] = mem[rd_ptr[g][aw-1:0]];

      hs_fanout_port #(
         .data_width(data_width),
         .ptr_w     (ptr_w)
      ) u_port (
         .clk       (clk),
         .rst_n     (rst_n),
         .req       (req_r[g]),
         .wr_ptr    (wr_ptr),
         .rd_word   (rd_word[g]),
         .rd_ptr    (rd_ptr[g]),
         .rd_ptr_nxt(rd_ptr_nxt[g]),
         .ack       (ack_r[g]),
         .dout      (dout[data_width*g +: data_width])
`ifdef HS_FANOUT_STATS_EN
         ,
         .count_out (count_out[HS_CNT_W*g +: HS_CNT_W])
`endif
      );
   end
endmodule

// File: tb/tb_hs_fanout_fifo.sv
// Bench for hs_fanout_fifo: cycle table for latency/hold behaviour, then scoreboarded streams.
module tb_hs_fanout_fifo;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int NC    = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_l;
   logic             ack_l;
   logic [DW-1:0]    din;
   logic [NC-1:0]    req_r;
   logic [NC-1:0]    ack_r;
   logic [DW*NC-1:0] dout;
`ifdef HS_FANOUT_STATS_EN
   logic [31:0]      count_in;
   logic [32*NC-1:0] count_out;
`endif

   hs_fanout_fifo #(.data_width(DW), .depth(DEPTH), .output_size(NC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_l    (req_l),
      .ack_l    (ack_l),
      .din      (din),
      .req_r    (req_r),
      .ack_r    (ack_r),
`ifdef HS_FANOUT_STATS_EN
      .count_in (count_in),
      .count_out(count_out),
`endif
      .dout     (dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          ack;
      logic [DW-1:0] din;
      logic [NC-1:0] rq;
      logic          e_req_l;
      logic [NC-1:0] e_ack;
      logic [DW-1:0] e_d0;
      logic [DW-1:0] e_d1;
   } vec_t;

   vec_t          tbl [10];
   int            n_vec = 0;
   int            n_bad = 0;
   int            n_acks = 0;
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic [NC-1:0] req_mask;
   logic [NC-1:0] prev_ack;
   bit            stall_en;
   int            prod_rate;
   int            sent;
   int            send_limit;
   logic [DW-1:0] next_word;

   // Entered and left at 1 time unit after a rising edge; the upstream
   // responder answers a raised req_l in the same cycle.
   task automatic step();
      logic [DW-1:0] got;
      logic [DW-1:0] want;
      req_r = stall_en ? NC'($urandom_range(0, (1 << NC) - 1)) : req_mask;
      ack_l = 1'b0;
      if (req_l && sent < send_limit && $urandom_range(0, 99) < prod_rate) begin
         ack_l = 1'b1;
         din   = next_word;
      end
      @(negedge clk);
      for (int k = 0; k < NC; k++) begin
         if (ack_r[k]) begin
            got = dout[DW*k +: DW];
            n_acks++;
            n_vec++;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
               n_bad++;
               $display("FAIL spurious_ack c%0d: ack with dout %h, required no ack (nothing stored)", k, got);
            end else begin
               if (k == 0) want = q0.pop_front();
               else        want = q1.pop_front();
               if (got !== want || prev_ack[k]) begin
                  n_bad++;
                  $display("FAIL data c%0d: dout %h back_to_back %b, required %h back_to_back 0",
                           k, got, prev_ack[k], want);
               end
            end
         end
      end
      prev_ack = ack_r;
      if (ack_l) begin
         q0.push_back(din);
         q1.push_back(din);
         sent++;
         next_word++;
         n_vec++;
         if (q0.size() > DEPTH || q1.size() > DEPTH) begin
            n_bad++;
            $display("FAIL occupancy: backlog c0 %0d c1 %0d, required at most %0d", q0.size(), q1.size(), DEPTH);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string name);
      n_vec++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL %s: undelivered c0 %0d c1 %0d, required 0 and 0", name, q0.size(), q1.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      int acks_before;
      rst_n = 1'b0; ack_l = 1'b0; din = '0; req_r = '0;
      req_mask = '0; prev_ack = '0; stall_en = 0; prod_rate = 100;
      sent = 0; send_limit = 0; next_word = '0;

      //            ack   din      rq     req_l ack_r  dout0    dout1
      tbl[0] = '{1'b0, 32'h00, 2'b11, 1'b0, 2'b00, 32'h00, 32'h00};
      tbl[1] = '{1'b1, 32'h11, 2'b11, 1'b1, 2'b00, 32'h00, 32'h00};
      tbl[2] = '{1'b0, 32'h00, 2'b11, 1'b1, 2'b00, 32'h00, 32'h00};
      tbl[3] = '{1'b0, 32'h00, 2'b11, 1'b1, 2'b11, 32'h11, 32'h11};
      tbl[4] = '{1'b0, 32'h00, 2'b11, 1'b1, 2'b00, 32'h11, 32'h11};
      tbl[5] = '{1'b1, 32'h22, 2'b01, 1'b1, 2'b00, 32'h11, 32'h11};
      tbl[6] = '{1'b0, 32'h00, 2'b01, 1'b1, 2'b00, 32'h11, 32'h11};
      tbl[7] = '{1'b0, 32'h00, 2'b01, 1'b1, 2'b01, 32'h22, 32'h11};
      tbl[8] = '{1'b0, 32'h00, 2'b11, 1'b1, 2'b00, 32'h22, 32'h11};
      tbl[9] = '{1'b0, 32'h00, 2'b11, 1'b1, 2'b10, 32'h22, 32'h22};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         ack_l = tbl[i].ack;
         din   = tbl[i].din;
         req_r = tbl[i].rq;
         @(negedge clk);
         n_vec++;
         if (req_l !== tbl[i].e_req_l || ack_r !== tbl[i].e_ack ||
             dout[DW-1:0] !== tbl[i].e_d0 || dout[2*DW-1:DW] !== tbl[i].e_d1) begin
            n_bad++;
            $display("FAIL vec%0d: req_l=%b ack_r=%b dout0=%h dout1=%h, required req_l=%b ack_r=%b dout0=%h dout1=%h",
                     i, req_l, ack_r, dout[DW-1:0], dout[2*DW-1:DW],
                     tbl[i].e_req_l, tbl[i].e_ack, tbl[i].e_d0, tbl[i].e_d1);
         end
         prev_ack = ack_r;
         @(posedge clk);
         #1;
      end
      ack_l = 1'b0;

      // Consumer 1 idle: its backlog fills the buffer and holds req_l low.
      next_word = '0; req_mask = 2'b01; send_limit = sent + 4; hi = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (c >= 20 && req_l) hi++;
      end
      n_vec++;
      if (hi != 0 || q0.size() != 0 || q1.size() != 4) begin
         n_bad++;
         $display("FAIL idle_hold: req_l high %0d cycles, backlog c0 %0d c1 %0d, required 0, 0, 4",
                  hi, q0.size(), q1.size());
      end
      req_mask = 2'b11;
      for (int c = 0; c < 40 && q1.size() != 0; c++) step();
      step();
      step();
      check_drained("idle_release_drain");
      n_vec++;
      if (req_l !== 1'b1) begin
         n_bad++;
         $display("FAIL idle_release_req: req_l=%b, required 1", req_l);
      end

      // Back-to-back stream, all consumers always requesting.
      next_word = '0; send_limit = sent + 5000;
      for (int c = 0; c < 15000 && (sent < send_limit || q0.size() != 0 || q1.size() != 0); c++) step();
      check_drained("stream_5000");
      n_vec++;
      if (sent != send_limit) begin
         n_bad++;
         $display("FAIL stream_count: sent %0d, required %0d", sent, send_limit);
      end

      // Random consumer stalls with a bursty producer.
      stall_en = 1; prod_rate = 50; send_limit = sent + 300;
      for (int c = 0; c < 4000 && sent < send_limit; c++) step();
      stall_en = 0; prod_rate = 100;
      for (int c = 0; c < 100 && (q0.size() != 0 || q1.size() != 0); c++) step();
      check_drained("random_stall");

      // Reset mid-stream with three words stored.
      req_mask = 2'b00; send_limit = sent + 3;
      for (int c = 0; c < 20 && sent < send_limit; c++) step();
      rst_n = 1'b0;
      ack_l = 1'b1;
      din   = 32'hDEAD_BEEF;
      #1;
      n_vec++;
      if (req_l !== 1'b0 || ack_r !== '0 || dout !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: req_l=%b ack_r=%b dout=%h, required 0 0 0", req_l, ack_r, dout);
      end
      q0.delete();
      q1.delete();
      prev_ack = '0;
      repeat (2) @(posedge clk);
      #1;
      ack_l = 1'b0;
      rst_n = 1'b1;
      req_mask = 2'b11; send_limit = sent;
      acks_before = n_acks;
      for (int c = 0; c < 6; c++) step();
      n_vec++;
      if (n_acks != acks_before) begin
         n_bad++;
         $display("FAIL reset_quiet: %0d acks after reset, required 0", n_acks - acks_before);
      end

      // Ten post-reset words; the first must be the first delivered.
      next_word = 32'h5A00; send_limit = sent + 10;
      for (int c = 0; c < 200 && (sent < send_limit || q0.size() != 0 || q1.size() != 0); c++) step();
      check_drained("post_reset");
`ifdef HS_FANOUT_STATS_EN
      n_vec++;
      if (count_in !== 32'd10 || count_out[31:0] !== 32'd10 || count_out[63:32] !== 32'd10) begin
         n_bad++;
         $display("FAIL stats: count_in %0d count_out0 %0d count_out1 %0d, required 10 10 10",
                  count_in, count_out[31:0], count_out[63:32]);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
